// File: rtl/gpio_rd_packetizer_if.sv
`default_nettype none
// ============================================================================
// gpio_rd_packetizer_if : read-FIFO and host return-channel bundle
// Rev 1.0
// ============================================================================
interface gpio_rd_packetizer_if #(
  parameter int GPIO_FIFO_WIDTH   = 8,
  parameter int DATA_PACKET_WIDTH = 51
);
  logic                         rd_gpio_f_empty;
  logic [GPIO_FIFO_WIDTH-1:0]   rd_gpio_fifo_data;
  logic                         rd_gpio_fifo_en;
  logic                         flush;
  logic [DATA_PACKET_WIDTH-1:0] pkt_data;
  logic                         pkt_valid;
  logic                         pkt_ready;

  modport slave (
    input  rd_gpio_f_empty, rd_gpio_fifo_data, flush, pkt_ready,
    output rd_gpio_fifo_en, pkt_data, pkt_valid
  );

  modport master (
    output rd_gpio_f_empty, rd_gpio_fifo_data, flush, pkt_ready,
    input  rd_gpio_fifo_en, pkt_data, pkt_valid
  );
endinterface
`default_nettype wire

// File: rtl/gpio_rd_packetizer.sv
`default_nettype none
// ============================================================================
// gpio_rd_packetizer : packs GPIO read-FIFO bytes into 51-bit host packets
// Rev 1.0
// ============================================================================
module gpio_rd_packetizer #(
  parameter int         DATA_PACKET_WIDTH = 51,
  parameter int         GPIO_FIFO_WIDTH   = 8,
  parameter logic [2:0] PERIPH_ID         = 3'd1,
  parameter int         TIMEOUT_CYCLES    = 16
) (
  input  wire logic           clk1,
  input  wire logic           rst_n,
  gpio_rd_packetizer_if.slave bus
);
  localparam int         c_LANES     = 5;
  localparam int         c_LANE_BITS = c_LANES * GPIO_FIFO_WIDTH;
  localparam logic [2:0] c_FULL      = 3'd5;
  localparam logic [2:0] c_LAST      = 3'd4;
  localparam logic [7:0] c_IDLE_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_READ    = 2'd1,
    S_CAPT    = 2'd2,
    S_SEND    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [2:0]             r_count;
  logic [c_LANE_BITS-1:0] r_lanes;
  logic [7:0]             r_idle;
  logic                   w_has_data;
  logic                   w_send_req;

  // Available FIFO data outranks flush/timeout so a racing byte lands in this packet.
  assign w_has_data = !bus.rd_gpio_f_empty && (r_count < c_FULL);
  assign w_send_req = (r_count != 3'd0) && (bus.flush || (r_idle == c_IDLE_LAST));

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_COLLECT: begin
        if (w_has_data) begin
          w_next = S_READ;
        end else if (w_send_req) begin
          w_next = S_SEND;
        end
      end
      S_READ:  w_next = S_CAPT;
      S_CAPT:  w_next = (r_count == c_LAST) ? S_SEND : S_COLLECT;
      S_SEND:  w_next = bus.pkt_ready ? S_COLLECT : S_SEND;
      default: w_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_count <= '0;
      r_lanes <= '0;
      r_idle  <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if ((r_count != 3'd0) && bus.rd_gpio_f_empty && (r_idle != 8'hFF)) begin
            r_idle <= r_idle + 8'd1;
          end
        end
        S_CAPT: begin
          for (int k = 0; k < c_LANES; k++) begin
            if (r_count == 3'(k)) begin
              r_lanes[k*GPIO_FIFO_WIDTH +: GPIO_FIFO_WIDTH] <= bus.rd_gpio_fifo_data;
            end
          end
          r_count <= r_count + 3'd1;
          r_idle  <= '0;
        end
        S_SEND: begin
          r_idle <= '0;
          if (bus.pkt_ready) begin
            r_count <= '0;
            r_lanes <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Packet bus reads as zero outside SEND so reset and idle show an all-zero bus.
  assign bus.rd_gpio_fifo_en = (r_state == S_READ);
  assign bus.pkt_valid       = (r_state == S_SEND);
  assign bus.pkt_data        = (r_state == S_SEND) ?
                               DATA_PACKET_WIDTH'({PERIPH_ID, 5'd0, r_count, r_lanes}) :
                               '0;
endmodule
`default_nettype wire

// File: tb/tb_gpio_rd_packetizer.sv
`default_nettype none
// ============================================================================
// tb_gpio_rd_packetizer : bench with FIFO model and packet reference model
// Rev 1.0
// ============================================================================
module tb_gpio_rd_packetizer;
  localparam logic [2:0] PID = 3'd1;
  localparam int         TMO = 16;

  logic clk1 = 1'b0;
  logic rst_n;
  always #5 clk1 = ~clk1;

  gpio_rd_packetizer_if #(.GPIO_FIFO_WIDTH(8), .DATA_PACKET_WIDTH(51)) bus ();

  gpio_rd_packetizer #(
    .DATA_PACKET_WIDTH(51),
    .GPIO_FIFO_WIDTH  (8),
    .PERIPH_ID        (PID),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk1 (clk1),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          pops = 0;
  int          valid_cycles = 0;
  logic [7:0]  fifo_q[$];
  logic [50:0] got[$];
  logic        prev_en = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [50:0] prev_data = '0;

  function automatic logic [50:0] make_pkt(input logic [7:0] b[$]);
    logic [39:0] lanes;
    lanes = '0;
    for (int k = 0; k < b.size(); k++) lanes[8*k +: 8] = b[k];
    return {PID, 5'd0, 3'(b.size()), lanes};
  endfunction

  // One clock: protocol checks on pre-edge values, then the FIFO answers any pop.
  task automatic step();
    logic        en_s, v_s, r_s;
    logic [50:0] d_s;
    en_s = bus.rd_gpio_fifo_en;
    v_s  = bus.pkt_valid;
    r_s  = bus.pkt_ready;
    d_s  = bus.pkt_data;
    if (en_s === 1'b1) begin
      n_cmp++;
      if (v_s !== 1'b0 || prev_en !== 1'b0) begin
        n_bad++;
        $display("FAIL pop_qualify: valid=%0b prev_en=%0b, required 0/0", v_s, prev_en);
      end
    end
    if (prev_valid && !prev_ready) begin
      n_cmp++;
      if (v_s !== 1'b1 || d_s !== prev_data) begin
        n_bad++;
        $display("FAIL stall_stable: valid=%0b data=%h, required 1 data=%h", v_s, d_s, prev_data);
      end
    end
    if (prev_valid && prev_ready) begin
      n_cmp++;
      if (v_s !== 1'b0) begin
        n_bad++;
        $display("FAIL valid_drop: valid=%0b after transfer, required 0", v_s);
      end
    end
    if (v_s === 1'b1) valid_cycles++;
    if (v_s === 1'b1 && r_s === 1'b1) got.push_back(d_s);
    prev_en    = (en_s === 1'b1);
    prev_valid = (v_s === 1'b1);
    prev_ready = (r_s === 1'b1);
    prev_data  = d_s;
    @(posedge clk1);
    #1;
    if (en_s === 1'b1) begin
      n_cmp++;
      if (fifo_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_empty: fifo size=0, required >0 at pop");
      end else begin
        bus.rd_gpio_fifo_data = fifo_q.pop_front();
        pops++;
      end
    end
    bus.rd_gpio_f_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    bus.rd_gpio_f_empty = 1'b0;
  endtask

  task automatic wait_pkts(input int n, input int bound, input string name);
    int k;
    k = 0;
    while (got.size() < n && k < bound) begin
      step();
      k++;
    end
    n_cmp++;
    if (got.size() < n) begin
      n_bad++;
      $display("FAIL %s_wait: got %0d packets, required %0d within %0d cycles", name, got.size(), n, bound);
    end
  endtask

  task automatic check_pkt(input int idx, input logic [50:0] exp, input string name);
    n_cmp++;
    if (got.size() <= idx) begin
      n_bad++;
      $display("FAIL %s: packet %0d missing, required %h", name, idx, exp);
    end else if (got[idx] !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got[idx], exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_cmp++;
    if (bus.rd_gpio_fifo_en !== 1'b0 || bus.pkt_valid !== 1'b0 || bus.pkt_data !== 51'd0) begin
      n_bad++;
      $display("FAIL %s: en=%b valid=%b data=%h, required 0 0 0", name,
               bus.rd_gpio_fifo_en, bus.pkt_valid, bus.pkt_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.pkt_ready = 1'b0;
    bus.rd_gpio_f_empty = 1'b1;
    bus.rd_gpio_fifo_data = '0;
    step();
    step();
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    got.delete();
    pops = 0;
  endtask

  task automatic test_full_packet();
    logic [7:0] b[$];
    int t;
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    got.delete();
    pops = 0;
    bus.pkt_ready = 1'b1;
    foreach (b[i]) push(b[i]);
    t = 0;
    while (bus.pkt_valid !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    n_cmp++;
    if (t != 15) begin
      n_bad++;
      $display("FAIL full_latency: valid after %0d cycles, required 15", t);
    end
    wait_pkts(1, 10, "full");
    n_cmp++;
    if (pops != 5) begin
      n_bad++;
      $display("FAIL full_pops: %0d pops, required 5", pops);
    end
    check_pkt(0, make_pkt(b), "full_model");
    check_pkt(0, {3'd1, 5'd0, 3'd5, 40'h5544332211}, "full_literal");
  endtask

  task automatic test_timeout();
    int t, t_empty, t_valid;
    logic [7:0] b[$];
    b = '{8'hA5, 8'h3C};
    got.delete();
    bus.pkt_ready = 1'b1;
    foreach (b[i]) push(b[i]);
    t = 0;
    t_empty = -1;
    t_valid = -1;
    while (t < 80 && t_valid < 0) begin
      step();
      t++;
      if (t_empty < 0 && bus.rd_gpio_f_empty === 1'b1) t_empty = t;
      if (bus.pkt_valid === 1'b1) t_valid = t;
    end
    n_cmp++;
    if (t_empty < 0 || t_valid - t_empty != TMO + 1) begin
      n_bad++;
      $display("FAIL timeout_latency: valid %0d cycles after empty, required %0d", t_valid - t_empty, TMO + 1);
    end
    wait_pkts(1, 5, "timeout");
    check_pkt(0, make_pkt(b), "timeout_pkt");
    n_cmp++;
    if (got.size() > 0 && (got[0][15:0] !== 16'h3CA5 || got[0][39:16] !== 24'd0 || got[0][42:40] !== 3'd2)) begin
      n_bad++;
      $display("FAIL timeout_fields: data=%h, required count 2 lanes 3CA5", got[0]);
    end
  endtask

  task automatic test_flush();
    int vc;
    logic [7:0] b[$];
    b = '{8'h7E};
    got.delete();
    bus.pkt_ready = 1'b1;
    push(b[0]);
    repeat (3) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    n_cmp++;
    if (bus.pkt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_immediate: valid=%b, required 1", bus.pkt_valid);
    end
    wait_pkts(1, 5, "flush");
    check_pkt(0, make_pkt(b), "flush_pkt");
    repeat (2) step();
    vc = valid_cycles;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (30) step();
    n_cmp++;
    if (valid_cycles != vc || got.size() != 1) begin
      n_bad++;
      $display("FAIL flush_empty: %0d valid cycles %0d packets, required 0 and 1", valid_cycles - vc, got.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[$];
    logic [7:0] first[$];
    logic [7:0] rest[$];
    int t;
    got.delete();
    pops = 0;
    bus.pkt_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      b.push_back(8'($urandom));
      if (i < 5) first.push_back(b[i]);
      else rest.push_back(b[i]);
      push(b[i]);
    end
    t = 0;
    while (bus.pkt_valid !== 1'b1 && t < 60) begin
      step();
      t++;
    end
    repeat (20) step();
    n_cmp++;
    if (pops != 5 || bus.pkt_valid !== 1'b1 || bus.pkt_data !== make_pkt(first)) begin
      n_bad++;
      $display("FAIL bp_hold: pops=%0d valid=%b data=%h, required 5 1 %h", pops, bus.pkt_valid, bus.pkt_data, make_pkt(first));
    end
    bus.pkt_ready = 1'b1;
    wait_pkts(2, 80, "bp");
    check_pkt(0, make_pkt(first), "bp_first");
    check_pkt(1, make_pkt(rest), "bp_second");
  endtask

  task automatic test_reset_midpacket();
    logic [7:0] nb[$];
    int t;
    got.delete();
    pops = 0;
    bus.pkt_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    t = 0;
    while (pops < 4 && t < 40) begin
      step();
      t++;
    end
    n_cmp++;
    if (pops != 4) begin
      n_bad++;
      $display("FAIL rst_mid_pops: %0d pops, required 4", pops);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_outputs_zero("rst_mid_outputs");
    nb = '{8'($urandom), 8'($urandom)};
    foreach (nb[i]) push(nb[i]);
    wait_pkts(1, 60, "rst_mid");
    check_pkt(0, make_pkt(nb), "rst_mid_pkt");
  endtask

  task automatic test_empty();
    int p0, vc;
    p0 = pops;
    vc = valid_cycles;
    repeat (60) step();
    n_cmp++;
    if (pops != p0 || valid_cycles != vc) begin
      n_bad++;
      $display("FAIL empty_idle: %0d pops %0d valid cycles, required 0 0", pops - p0, valid_cycles - vc);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [7:0]  b[$];
      logic [50:0] exp_q[$];
      int n, k;
      n = $urandom_range(1, 12);
      got.delete();
      for (int i = 0; i < n; i++) begin
        b.push_back(8'($urandom));
        push(b[i]);
      end
      for (int p = 0; p < (n + 4) / 5; p++) begin
        logic [7:0] c[$];
        for (int j = 5 * p; j < n && j < 5 * p + 5; j++) c.push_back(b[j]);
        exp_q.push_back(make_pkt(c));
      end
      k = 0;
      while (got.size() < exp_q.size() && k < 400) begin
        bus.pkt_ready = ($urandom_range(0, 3) != 0);
        step();
        k++;
      end
      bus.pkt_ready = 1'b1;
      repeat (25) step();
      n_cmp++;
      if (got.size() != exp_q.size()) begin
        n_bad++;
        $display("FAIL rand_count: iter %0d got %0d packets, required %0d", it, got.size(), exp_q.size());
      end
      foreach (exp_q[p]) check_pkt(p, exp_q[p], "rand_pkt");
    end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_timeout();
    test_flush();
    test_backpressure();
    test_reset_midpacket();
    test_empty();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
